// File: rtl/bullsCows_pkg.sv
// rtl/bullsCows_pkg.sv - shared types, constants and guess validation for the bullsCows game
package bullsCows_pkg;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;

   typedef logic [DIGITS*DIGIT_W-1:0] guess_t;

   typedef enum logic [1:0] {
      IDLE,
      DB_PRESS,
      HELD,
      DB_RELEASE
   } in_state_t;

   // Also used by the game core to vet the secret.
   function automatic logic digits_valid(input guess_t g, input bit decimal_only);
      logic               ok;
      logic [DIGIT_W-1:0] a;
      logic [DIGIT_W-1:0] b;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         a = g[i*DIGIT_W +: DIGIT_W];
         if (decimal_only && (a > DIGIT_W'(9))) ok = 1'b0;
         for (int j = i + 1; j < DIGITS; j++) begin
            b = g[j*DIGIT_W +: DIGIT_W];
            if (a == b) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flip-flop synchroniser, async active-high reset to 0
module sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/guess_input_ctrl.sv
// rtl/guess_input_ctrl.sv - switch/button conditioning, debounce and guess validation
module guess_input_ctrl
   import bullsCows_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int SYNC_STAGES         = 2,
   parameter bit DECIMAL_ONLY        = 1'b1,
   parameter int INVALID_HOLD_CYCLES = 200_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  guess_t     sw,
   input  logic       btn_raw,
   output guess_t     guess,
   output logic       confirm,
   output logic       invalid,
   output logic [3:0] reject_count
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(INVALID_HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(INVALID_HOLD_CYCLES - 1);

   guess_t            sw_s;
   logic              btn_s;
   logic              sw_ok;
   logic              accept;

   in_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   guess_t            guess_q, guess_d;
   logic              confirm_q, confirm_d;
   logic              invalid_q, invalid_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        rej_q, rej_d;

   sync_ff #(.WIDTH(16), .STAGES(SYNC_STAGES)) u_sw_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   (sw),
      .q_o   (sw_s)
   );

   sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_btn_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   (btn_raw),
      .q_o   (btn_s)
   );

   assign sw_ok = digits_valid(sw_s, DECIMAL_ONLY);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      guess_d   = guess_q;
      confirm_d = 1'b0;
      invalid_d = invalid_q;
      hold_d    = hold_q;
      rej_d     = rej_q;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            if (btn_s) begin
               cnt_d   = '0;
               state_d = DB_PRESS;
            end
         end
         DB_PRESS: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               cnt_d   = '0;
               state_d = DB_RELEASE;
            end
         end
         DB_RELEASE: begin
            if (btn_s) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh rejection reloads the hold timer even if invalid is already up.
      if (accept && sw_ok) begin
         guess_d   = sw_s;
         confirm_d = 1'b1;
         invalid_d = 1'b0;
         hold_d    = '0;
      end else if (accept) begin
         invalid_d = 1'b1;
         hold_d    = HOLD_LOAD;
         if (rej_q != 4'hF) rej_d = rej_q + 4'd1;
      end else if (invalid_q) begin
         if (hold_q == '0) invalid_d = 1'b0;
         else              hold_d    = hold_q - HOLD_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         guess_q   <= '0;
         confirm_q <= 1'b0;
         invalid_q <= 1'b0;
         hold_q    <= '0;
         rej_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         guess_q   <= guess_d;
         confirm_q <= confirm_d;
         invalid_q <= invalid_d;
         hold_q    <= hold_d;
         rej_q     <= rej_d;
      end
   end

   assign guess        = guess_q;
   assign confirm      = confirm_q;
   assign invalid      = invalid_q;
   assign reject_count = rej_q;

endmodule

// File: tb/tb_guess_input_ctrl.sv
// tb/tb_guess_input_ctrl.sv - scoreboard bench for guess_input_ctrl (decimal and hex instances)
module tb_guess_input_ctrl;

   localparam int DB     = 4;
   localparam int SYNC   = 2;
   localparam int HOLD_D = 8;
   localparam int HOLD_H = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] sw;
   logic        btn_raw;
   logic [15:0] guess_dec, guess_hex;
   logic        conf_dec, conf_hex, inv_dec, inv_hex;
   logic [3:0]  rc_dec, rc_hex;

   always #5 clock = ~clock;

   guess_input_ctrl #(
      .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC), .DECIMAL_ONLY(1'b1), .INVALID_HOLD_CYCLES(HOLD_D)
   ) dut (
      .clock(clock), .reset(reset), .sw(sw), .btn_raw(btn_raw),
      .guess(guess_dec), .confirm(conf_dec), .invalid(inv_dec), .reject_count(rc_dec)
   );

   guess_input_ctrl #(
      .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC), .DECIMAL_ONLY(1'b0), .INVALID_HOLD_CYCLES(HOLD_H)
   ) dut_hex (
      .clock(clock), .reset(reset), .sw(sw), .btn_raw(btn_raw),
      .guess(guess_hex), .confirm(conf_hex), .invalid(inv_hex), .reject_count(rc_hex)
   );

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } ev_t;

   ev_t         q_dec[$];
   ev_t         q_hex[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          started = 1'b0;
   bit          btn_pipe[$];
   logic [15:0] sw_pipe[$];
   bit          deb;
   int          ones, zeros;
   logic [15:0] exp_guess [2];
   int          inv_left  [2];
   int          exp_rej   [2];
   int          last_conf [2];
   logic [15:0] pool [10] = '{16'h1234, 16'h1123, 16'h12A4, 16'h9876, 16'h5555,
                              16'h0F3C, 16'hABCD, 16'h0123, 16'h3210, 16'h7777};

   // A guess is acceptable when no digit repeats (and, for decimal, none exceeds 9).
   function automatic bit model_ok(input logic [15:0] v, input bit dec);
      bit [15:0]   seen;
      logic [15:0] t;
      int          d;
      seen = '0;
      t    = v;
      for (int i = 0; i < 4; i++) begin
         d = int'(t[3:0]);
         t = t >> 4;
         if (dec && d > 9) return 1'b0;
         if (seen[d]) return 1'b0;
         seen[d] = 1'b1;
      end
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_drained();
      tests++;
      if (q_dec.size() != 0 || q_hex.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d/%0d expected confirms never observed", q_dec.size(), q_hex.size());
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      btn_pipe.delete();
      sw_pipe.delete();
      for (int i = 0; i < SYNC; i++) begin
         btn_pipe.push_back(1'b0);
         sw_pipe.push_back(16'h0);
      end
      deb   = 1'b0;
      ones  = 0;
      zeros = 0;
      for (int m = 0; m < 2; m++) begin
         exp_guess[m] = 16'h0;
         inv_left[m]  = 0;
         exp_rej[m]   = 0;
         last_conf[m] = -1;
      end
      q_dec.delete();
      q_hex.delete();
   endtask

   // Press/release is recognised after DB+1 consecutive agreeing synchronised samples.
   task automatic model_edge(input bit b, input logic [15:0] s);
      bit          bs;
      bit          acc;
      logic [15:0] ss;
      ev_t         e;
      cyc++;
      bs = btn_pipe.pop_front();
      btn_pipe.push_back(b);
      ss = sw_pipe.pop_front();
      sw_pipe.push_back(s);
      acc = 1'b0;
      if (!deb) begin
         ones = bs ? ones + 1 : 0;
         if (ones == DB + 1) begin
            deb  = 1'b1;
            ones = 0;
            acc  = 1'b1;
         end
      end else begin
         zeros = bs ? 0 : zeros + 1;
         if (zeros == DB + 1) begin
            deb   = 1'b0;
            zeros = 0;
         end
      end
      for (int m = 0; m < 2; m++) begin
         if (acc && model_ok(ss, m == 0)) begin
            exp_guess[m] = ss;
            inv_left[m]  = 0;
            e.cyc = cyc;
            e.val = ss;
            if (m == 0) q_dec.push_back(e);
            else        q_hex.push_back(e);
         end else if (acc) begin
            inv_left[m] = (m == 0) ? HOLD_D : HOLD_H;
            if (exp_rej[m] < 15) exp_rej[m]++;
         end else if (inv_left[m] > 0) begin
            inv_left[m]--;
         end
      end
   endtask

   task automatic step(input bit b, input logic [15:0] s);
      btn_raw = b;
      sw      = s;
      @(posedge clock);
      model_edge(b, s);
      #1;
   endtask

   task automatic press(input logic [15:0] v, input int hi, input int lo);
      repeat (hi) step(1'b1, v);
      repeat (lo) step(1'b0, v);
   endtask

   task automatic apply_reset();
      check_drained();
      reset   = 1'b1;
      btn_raw = 1'b0;
      #1;
      chk("rst_now_guess", {16'h0, guess_dec}, 32'h0);
      chk("rst_now_conf", {31'h0, conf_dec}, 32'h0);
      chk("rst_now_inv", {31'h0, inv_dec}, 32'h0);
      chk("rst_now_rc", {28'h0, rc_dec}, 32'h0);
      chk("rst_now_guess_hex", {16'h0, guess_hex}, 32'h0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_inst(input int m, input logic conf, input logic [15:0] g,
                             input logic inv, input logic [3:0] rc);
      ev_t e;
      bit  have;
      if (m == 0) begin
         while (q_dec.size() > 0 && q_dec[0].cyc < cyc) begin
            e = q_dec.pop_front();
            tests++; fails++;
            $display("FAIL missing_confirm dec: expected at cycle %0d value %h, confirm absent", e.cyc, e.val);
         end
      end else begin
         while (q_hex.size() > 0 && q_hex[0].cyc < cyc) begin
            e = q_hex.pop_front();
            tests++; fails++;
            $display("FAIL missing_confirm hex: expected at cycle %0d value %h, confirm absent", e.cyc, e.val);
         end
      end
      if (conf) begin
         have = 1'b0;
         if (m == 0 && q_dec.size() > 0) begin e = q_dec.pop_front(); have = 1'b1; end
         if (m == 1 && q_hex.size() > 0) begin e = q_hex.pop_front(); have = 1'b1; end
         tests++;
         if (!have) begin
            fails++;
            $display("FAIL unexpected_confirm inst%0d: confirm at cycle %0d guess %h, none expected", m, cyc, g);
         end else if (e.cyc != cyc || e.val !== g) begin
            fails++;
            $display("FAIL confirm inst%0d: got cycle %0d guess %h expected cycle %0d guess %h", m, cyc, g, e.cyc, e.val);
         end
         last_conf[m] = cyc;
      end
      tests++;
      if (g !== exp_guess[m]) begin
         fails++;
         $display("FAIL guess inst%0d: got %h expected %h (cycle %0d)", m, g, exp_guess[m], cyc);
      end
      tests++;
      if (inv !== (inv_left[m] > 0)) begin
         fails++;
         $display("FAIL invalid inst%0d: got %b expected %b (cycle %0d)", m, inv, inv_left[m] > 0, cyc);
      end
      tests++;
      if (rc !== 4'(exp_rej[m])) begin
         fails++;
         $display("FAIL reject_count inst%0d: got %0d expected %0d (cycle %0d)", m, rc, exp_rej[m], cyc);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         tests++;
         if (conf_dec || conf_hex || inv_dec || inv_hex || guess_dec != 16'h0 ||
             guess_hex != 16'h0 || rc_dec != 4'h0 || rc_hex != 4'h0) begin
            fails++;
            $display("FAIL reset_outputs: conf %b/%b inv %b/%b guess %h/%h rc %0d/%0d expected all 0",
                     conf_dec, conf_hex, inv_dec, inv_hex, guess_dec, guess_hex, rc_dec, rc_hex);
         end
      end else if (started) begin
         check_inst(0, conf_dec, guess_dec, inv_dec, rc_dec);
         check_inst(1, conf_hex, guess_hex, inv_hex, rc_hex);
      end
   end

   initial begin
      int          t0;
      int          lc;
      bit          lvl;
      int          len;
      logic [15:0] v;

      reset   = 1'b1;
      btn_raw = 1'b0;
      sw      = 16'h0;
      model_reset();
      repeat (2) @(posedge clock);
      #2;
      reset   = 1'b0;
      started = 1'b1;

      // clean press: confirm at edge 7
      repeat (12) step(1'b1, 16'h1234);
      chk("clean_latency", 32'(last_conf[0]), 32'd7);
      chk("clean_guess", {16'h0, guess_dec}, 32'h1234);
      repeat (8) step(1'b0, 16'h1234);

      // bounce then a long run
      press(16'h3456, 3, 1);
      t0 = cyc + 1;
      press(16'h3456, 10, 8);
      chk("bounce_latency", 32'(last_conf[0]), 32'(t0 + 6));
      lc = last_conf[0];
      for (int g = 1; g <= 3; g++) press(16'h4567, g, 5);
      chk("glitch_no_confirm", 32'(last_conf[0]), 32'(lc));

      // invalid values
      press(16'h1123, 6, 7);
      chk("reject_guess_kept", {16'h0, guess_dec}, 32'h3456);
      chk("reject_count_one", {28'h0, rc_dec}, 32'h1);
      press(16'h12A4, 6, 7);
      chk("hex_dec_rejected", {16'h0, guess_dec}, 32'h3456);
      chk("hex_accepted", {16'h0, guess_hex}, 32'h12A4);

      // long hold with switch change, bouncing release, then a fresh press from idle
      repeat (50) step(1'b1, 16'h2345);
      repeat (50) step(1'b1, 16'h6789);
      repeat (2) step(1'b0, 16'h6789);
      step(1'b1, 16'h6789);
      repeat (12) step(1'b0, 16'h6789);
      chk("hold_guess", {16'h0, guess_dec}, 32'h2345);
      t0 = cyc + 1;
      press(16'h4567, 8, 8);
      chk("after_release_latency", 32'(last_conf[0]), 32'(t0 + 6));

      // reject then accept while the long-hold instance is still invalid
      press(16'h5555, 6, 6);
      press(16'h9876, 6, 6);
      chk("accept_after_reject", {16'h0, guess_hex}, 32'h9876);

      // saturation
      apply_reset();
      repeat (17) press(16'h1123, 6, 6);
      chk("rc_saturate_dec", {28'h0, rc_dec}, 32'hF);
      chk("rc_saturate_hex", {28'h0, rc_hex}, 32'hF);

      // reset while the press counter is at 2
      press(16'h1234, 6, 6);
      press(16'h1123, 6, 6);
      repeat (5) step(1'b1, 16'h0987);
      apply_reset();
      repeat (12) step(1'b1, 16'h3579);
      chk("post_reset_latency", 32'(last_conf[0]), 32'd7);
      repeat (8) step(1'b0, 16'h3579);

      // randomised runs
      lvl = 1'b0;
      v   = pool[0];
      for (int r = 0; r < 160; r++) begin
         lvl = ~lvl;
         len = $urandom_range(1, 12);
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 3) == 0) v = 16'($urandom);
            else                           v = pool[$urandom_range(0, 9)];
         end
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 7) == 0) v = pool[$urandom_range(0, 9)];
            step(lvl, v);
         end
      end

      repeat (20) step(1'b0, 16'h0);
      check_drained();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
